// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - state encoding, width helpers and saturation constants for sfp_norm_seq
package sfp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } sfp_state_t;

  // width of S: the sum of COL unsigned BW-bit magnitudes cannot overflow this
  function automatic int sum_w(input int bw, input int col);
    return bw + $clog2(col);
  endfunction

  // lane index width, at least one bit
  function automatic int lane_w(input int col);
    return (col > 1) ? $clog2(col) : 1;
  endfunction

  // divider bit-counter width, counts 0..bw-1
  function automatic int cnt_w(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

  // largest positive signed bw-bit value, 2^(bw-1)-1
  function automatic logic [63:0] sat_pos(input int bw);
    return (64'd1 << (bw - 1)) - 64'd1;
  endfunction

  // -(2^(bw-1)-1) in two's complement, low bw bits are meaningful
  function automatic logic [63:0] sat_neg(input int bw);
    return ~((64'd1 << (bw - 1)) - 64'd2);
  endfunction

endpackage

// File: rtl/sfp_div_serial.sv
// rtl/sfp_div_serial.sv - BW-bit unsigned restoring divider, one quotient bit per cycle
module sfp_div_serial
  import sfp_pkg::*;
#(
  parameter int BW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [BW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic [BW-1:0] q_next,
  output logic          last
);

  localparam int CW = cnt_w(BW);

  logic [BW-1:0] rem;
  logic [BW-1:0] quo;
  logic [BW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic          active;
  logic [BW:0]   r2;
  logic [BW:0]   diff;
  logic          ge;
  logic          diff_unused;

  // one restoring step; q_next is the full quotient on the cycle last is high
  always_comb begin
    r2     = {rem, quo[BW-1]};
    diff   = r2 - {1'b0, dvs};
    ge     = (r2 >= {1'b0, dvs});
    q_next = {quo[BW-2:0], ge};
    last   = active && (cnt == CW'(BW - 1));
  end

  // the remainder is always below the divisor, so the top difference bit is never needed
  assign diff_unused = diff[BW];

  // start loads a new lane (and wins over the final step of the previous one)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      rem    <= '0;
      quo    <= dividend;
      dvs    <= divisor;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      rem <= ge ? diff[BW-1:0] : r2[BW-1:0];
      quo <= q_next;
      if (cnt == CW'(BW - 1)) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfp_norm_seq.sv
// rtl/sfp_norm_seq.sv - row normaliser |psum| / (sum|psum| >> SHIFT); SFP_SIGNED_OUT_EN gives signed results
module sfp_norm_seq
  import sfp_pkg::*;
#(
  parameter  int COL     = 8,
  parameter  int BW_PSUM = 20,
  parameter  int SHIFT   = 6,
  localparam int SUMW    = sum_w(BW_PSUM, COL)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BW_PSUM*COL-1:0] in_data,
  input  logic                   mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BW_PSUM*COL-1:0] out_data,
  output logic [SUMW-1:0]        out_sum,
  output logic                   div0,
  output logic                   busy
);

  localparam int LW = lane_w(COL);
  localparam logic [BW_PSUM-1:0] SAT_U = '1;
`ifdef SFP_SIGNED_OUT_EN
  localparam logic [BW_PSUM-1:0] SAT_P = BW_PSUM'(sat_pos(BW_PSUM));
  localparam logic [BW_PSUM-1:0] SAT_N = BW_PSUM'(sat_neg(BW_PSUM));
`endif

  sfp_state_t             state;
  logic [BW_PSUM*COL-1:0] row_q;
  logic                   mode_q;
  logic [BW_PSUM-1:0]     div_q;
  logic [LW-1:0]          lane;
  logic [LW-1:0]          lane_nx;
  logic [BW_PSUM-1:0]     res_q [COL];

  logic                   neg_c [COL];
  logic [BW_PSUM-1:0]     abs_c [COL];
  logic [BW_PSUM-1:0]     byp_c [COL];
  logic [SUMW-1:0]        sum_c;
  logic [BW_PSUM-1:0]     div_c;
  logic [BW_PSUM-1:0]     lane_res;

  logic                   dv_start;
  logic [BW_PSUM-1:0]     dv_dividend;
  logic [BW_PSUM-1:0]     dv_divisor;
  logic [BW_PSUM-1:0]     dv_q;
  logic                   dv_last;

  // per-lane magnitude, bypass value and the adder tree over the latched row
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < COL; k++) begin
      neg_c[k] = row_q[k*BW_PSUM + BW_PSUM - 1];
      abs_c[k] = neg_c[k] ? (~row_q[k*BW_PSUM +: BW_PSUM] + BW_PSUM'(1))
                          : row_q[k*BW_PSUM +: BW_PSUM];
`ifdef SFP_SIGNED_OUT_EN
      byp_c[k] = row_q[k*BW_PSUM +: BW_PSUM];
`else
      byp_c[k] = abs_c[k];
`endif
      sum_c = sum_c + SUMW'(abs_c[k]);
    end
    div_c = BW_PSUM'(sum_c >> SHIFT);
  end

  // divider feed: lane 0 starts from SUM, each later lane starts as the previous one finishes
  always_comb begin
    lane_nx     = lane + 1'b1;
    dv_start    = 1'b0;
    dv_dividend = abs_c[0];
    dv_divisor  = div_c;
    if (state == ST_SUM && !mode_q) begin
      dv_start = 1'b1;
    end else if (state == ST_DIV && dv_last && lane != LW'(COL - 1)) begin
      dv_start    = 1'b1;
      dv_dividend = abs_c[lane_nx];
      dv_divisor  = div_q;
    end
  end

  // finished quotient for the current lane, with divide-by-zero saturation and optional sign
  always_comb begin
`ifdef SFP_SIGNED_OUT_EN
    if (div0) begin
      lane_res = neg_c[lane] ? SAT_N : SAT_P;
    end else begin
      lane_res = neg_c[lane] ? (~dv_q + BW_PSUM'(1)) : dv_q;
    end
`else
    lane_res = div0 ? SAT_U : dv_q;
`endif
  end

  sfp_div_serial #(
    .BW (BW_PSUM)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (dv_start),
    .dividend (dv_dividend),
    .divisor  (dv_divisor),
    .q_next   (dv_q),
    .last     (dv_last)
  );

  // control FSM with registered handshake, status and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      div0      <= 1'b0;
      out_sum   <= '0;
      row_q     <= '0;
      mode_q    <= 1'b0;
      div_q     <= '0;
      lane      <= '0;
      for (int k = 0; k < COL; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            row_q    <= in_data;
            mode_q   <= mode;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SUM;
          end
        end
        ST_SUM: begin
          out_sum <= sum_c;
          div0    <= !mode_q && (div_c == '0);
          if (mode_q) begin
            for (int k = 0; k < COL; k++) begin
              res_q[k] <= byp_c[k];
            end
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            div_q <= div_c;
            lane  <= '0;
            state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (dv_last) begin
            res_q[lane] <= lane_res;
            if (lane == LW'(COL - 1)) begin
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end else begin
              lane <= lane_nx;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // flatten result lanes in input lane order
  always_comb begin
    out_data = '0;
    for (int k = 0; k < COL; k++) begin
      out_data[k*BW_PSUM +: BW_PSUM] = res_q[k];
    end
  end

endmodule

// File: tb/tb_sfp_norm_seq.sv
// tb/tb_sfp_norm_seq.sv - randomized self-checking bench for sfp_norm_seq against an arithmetic model
module tb_sfp_norm_seq;

  localparam int COL   = 8;
  localparam int BW    = 20;
  localparam int SHIFT = 6;
  localparam int SUMW  = BW + $clog2(COL);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [BW*COL-1:0] in_data;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic [BW*COL-1:0] out_data;
  logic [SUMW-1:0]   out_sum;
  logic              div0;
  logic              busy;

  sfp_norm_seq #(
    .COL     (COL),
    .BW_PSUM (BW),
    .SHIFT   (SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sum   (out_sum),
    .div0      (div0),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int          lanes [COL];
  logic [19:0] exp_lane [COL];
  longint      exp_sum;
  logic        exp_div0;
  logic        exp_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference: S = sum |x|, D = (S >> SHIFT) mod 2^BW, lane = |x| / D (all ones when D == 0)
  task automatic model(input logic m);
    longint s;
    longint d;
    longint mag;
    longint q;
    s = 0;
    for (int k = 0; k < COL; k++) s += (lanes[k] < 0) ? -lanes[k] : lanes[k];
    d = (s >> SHIFT) % (64'd1 << BW);
    exp_sum  = s;
    exp_mode = m;
    exp_div0 = !m && (d == 0);
    for (int k = 0; k < COL; k++) begin
      mag = (lanes[k] < 0) ? -lanes[k] : lanes[k];
      if (m) q = mag;
      else if (d == 0) q = (64'd1 << BW) - 1;
      else q = mag / d;
`ifdef SFP_SIGNED_OUT_EN
      if (!m && d == 0) q = (lanes[k] < 0) ? -((64'd1 << (BW - 1)) - 1) : (64'd1 << (BW - 1)) - 1;
      else if (lanes[k] < 0) q = -q;
`endif
      exp_lane[k] = 20'(q);
    end
  endtask

  task automatic push(input logic m);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    for (int k = 0; k < COL; k++) in_data[k*BW +: BW] = 20'(lanes[k]);
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < COL; k++) in_data[k*BW +: BW] = 20'($urandom);
    mode = 1'($urandom_range(0, 1));
    model(m);
  endtask

  task automatic wait_out(input string t);
    int lat;
    lat = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({t, "_latency"}, 64'(lat), exp_mode ? 64'd2 : 64'd162);
    for (int k = 0; k < COL; k++)
      chk($sformatf("%s_lane%0d", t, k), 64'(out_data[k*BW +: BW]), 64'(exp_lane[k]));
    chk({t, "_sum"}, 64'(out_sum), 64'(exp_sum));
    chk({t, "_div0"}, 64'(div0), 64'(exp_div0));
    chk({t, "_in_ready_busy"}, 64'({in_ready, busy}), 64'b01);
  endtask

  task automatic release_out(input string t);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({t, "_after_hs"}, 64'({out_valid, in_ready, busy}), 64'b000);
    @(negedge clk);
    chk({t, "_ready_again"}, 64'(in_ready), 64'd1);
  endtask

  task automatic chk_cleared(input string t);
    chk({t, "_ctl"}, 64'({in_ready, out_valid, busy, div0}), 64'b0000);
    chk({t, "_data_zero"}, 64'(out_data == '0), 64'd1);
    chk({t, "_sum"}, 64'(out_sum), 64'd0);
  endtask

  task automatic rand_row();
    int scale;
    int v;
    scale = $urandom_range(0, 19);
    for (int k = 0; k < COL; k++) begin
      v = int'($urandom_range(0, (1 << scale) - 1));
      if ($urandom_range(0, 1) == 1) v = -v;
      lanes[k] = v;
    end
  endtask

  initial begin
    int bad;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk_cleared("reset_hold");
    reset = 1'b1;
    @(negedge clk);
    chk("reset_rel_ready", 64'({in_ready, out_valid}), 64'b10);
    chk("reset_rel_data", 64'(out_data == '0), 64'd1);

    // all lanes 64: S=512, D=8, quotient 8
    for (int k = 0; k < COL; k++) lanes[k] = 64;
    push(1'b0);
    wait_out("t2");
    chk("t2_sum_const", 64'(out_sum), 64'd512);
    release_out("t2");

    // -128, 128, then zeros: S=256, D=4
    for (int k = 0; k < COL; k++) lanes[k] = 0;
    lanes[0] = -128;
    lanes[1] = 128;
    push(1'b0);
    wait_out("t3");
    release_out("t3");

    // all ones: D=0 saturates every lane with unchanged latency
    for (int k = 0; k < COL; k++) lanes[k] = 1;
    push(1'b0);
    wait_out("t4");
    chk("t4_div0_const", 64'(div0), 64'd1);
    release_out("t4");

    // most negative value everywhere: |x| = 2^19, S = 2^22, D = 2^16
    for (int k = 0; k < COL; k++) lanes[k] = -524288;
    push(1'b0);
    wait_out("minval");
    release_out("minval");

    // bypass with back-pressure, then an immediate second row
    for (int k = 0; k < COL; k++) lanes[k] = 7;
    lanes[0] = -5;
    push(1'b1);
    wait_out("t5");
    chk("t5_sum_const", 64'(out_sum), 64'd54);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_valid || in_ready) bad++;
      for (int k = 0; k < COL; k++) if (out_data[k*BW +: BW] !== exp_lane[k]) bad++;
      if (out_sum !== SUMW'(exp_sum)) bad++;
    end
    chk("t5_hold_stable", 64'(bad), 64'd0);
    release_out("t5");
    rand_row();
    push(1'b0);
    wait_out("t5b");
    release_out("t5b");

    // reset in the middle of a division
    rand_row();
    push(1'b0);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_cleared("t6_abort");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < COL; k++) lanes[k] = 1000 * (k + 1) * ((k % 2 == 1) ? -1 : 1);
    push(1'b0);
    wait_out("t6");
    release_out("t6");

    // randomized rows
    for (int r = 0; r < 14; r++) begin
      rand_row();
      push(1'($urandom_range(0, 3) == 0));
      wait_out($sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
